// File: rtl/iomem_gpio_if.sv
// Memory-mapped request/acknowledge bus used by the GPIO block.
// The master drives the request, and the slave returns ready and rdata.
interface iomem_gpio_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/iomem_gpio.sv
// GPIO block with OUT/OE registers, synchronized inputs, and edge-detect STATUS with an irq.
// Each access gets a single-cycle acknowledge, and the read data returns the register value from before any write.
module iomem_gpio #(
    parameter int         WIDTH       = 32,
    parameter logic [7:0] BASE_ADDR   = 8'h03,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    iomem_gpio_if.slave      bus,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    input  logic [WIDTH-1:0] gpio_in,
    output logic             irq
);
    localparam logic [5:0] OFF_OUT  = 6'd0;
    localparam logic [5:0] OFF_OE   = 6'd1;
    localparam logic [5:0] OFF_IN   = 6'd2;
    localparam logic [5:0] OFF_RISE = 6'd3;
    localparam logic [5:0] OFF_FALL = 6'd4;
    localparam logic [5:0] OFF_STAT = 6'd5;

    logic                              ready_q, ready_d;
    logic [31:0]                       rdata_q, rdata_d;
    logic [WIDTH-1:0]                  out_q, out_d, oe_q, oe_d;
    logic [WIDTH-1:0]                  rise_q, rise_d, fall_q, fall_d;
    logic [WIDTH-1:0]                  stat_q, stat_d, prev_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;

    logic             sel, wr;
    logic [5:0]       off;
    logic [31:0]      bmask, rd_word;
    logic [WIDTH-1:0] wm, wd, sync_in, evt, rd_reg, clr;
    logic             unused_bits;

    assign sel = bus.iomem_valid && !ready_q && (bus.iomem_addr[31:24] == BASE_ADDR);
    assign wr  = sel && (bus.iomem_wstrb != 4'b0000);
    assign off = bus.iomem_addr[7:2];

    always_comb begin
        bmask = '0;
        for (int n = 0; n < 4; n++) bmask[8*n +: 8] = {8{bus.iomem_wstrb[n]}};
    end

    assign wm = bmask[WIDTH-1:0];
    assign wd = bus.iomem_wdata[WIDTH-1:0];

    assign unused_bits = ^{bus.iomem_addr[23:8], bus.iomem_addr[1:0], bus.iomem_wdata, bmask};

    assign sync_in = sync_q[SYNC_STAGES-1];
    assign sync_d  = {sync_q[SYNC_STAGES-2:0], gpio_in};

    // An edge is defined as the difference between the last synchronizer stage and its one-cycle-delayed copy.
    assign evt = (sync_in & ~prev_q & rise_q) | (~sync_in & prev_q & fall_q);

    always_comb begin
        rd_reg = '0;
        case (off)
            OFF_OUT:  rd_reg = out_q;
            OFF_OE:   rd_reg = oe_q;
            OFF_IN:   rd_reg = sync_in;
            OFF_RISE: rd_reg = rise_q;
            OFF_FALL: rd_reg = fall_q;
            OFF_STAT: rd_reg = stat_q;
            default:  rd_reg = '0;
        endcase
        rd_word = '0;
        rd_word[WIDTH-1:0] = rd_reg;
    end

    always_comb begin
        ready_d = sel;
        rdata_d = sel ? rd_word : 32'h0;
        out_d   = out_q;
        oe_d    = oe_q;
        rise_d  = rise_q;
        fall_d  = fall_q;
        clr     = '0;
        if (wr) begin
            case (off)
                OFF_OUT:  out_d  = (out_q  & ~wm) | (wd & wm);
                OFF_OE:   oe_d   = (oe_q   & ~wm) | (wd & wm);
                OFF_RISE: rise_d = (rise_q & ~wm) | (wd & wm);
                OFF_FALL: fall_d = (fall_q & ~wm) | (wd & wm);
                OFF_STAT: clr    = wd & wm;
                default:  ;
            endcase
        end
        // Set is applied after clear, so a new edge survives a simultaneous W1C.
        stat_d = (stat_q & ~clr) | evt;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            out_q   <= '0;
            oe_q    <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            stat_q  <= '0;
            prev_q  <= '0;
            sync_q  <= '0;
        end else begin
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            stat_q  <= stat_d;
            prev_q  <= sync_in;
            sync_q  <= sync_d;
        end
    end

    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
    assign gpio_out        = out_q;
    assign gpio_oe         = oe_q;
    assign irq             = |stat_q;
endmodule
